// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// BTB entry layout, counter update and table index hashing.
package bpred_pkg;

    localparam int unsigned XLEN      = 32;
    // Tags are stored zero-extended to the widest possible tag (pc[31:2]).
    localparam int unsigned TAG_W     = XLEN - 2;
    // Widest index supported (ENTRIES up to 256).
    localparam int unsigned IDX_MAX_W = 8;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_RESET = CTR_WNT;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } bpred_entry_t;

    // Saturating 2-bit direction counter step.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
    endfunction

    // pc[iw+1:2], XORed with the history aligned to the index MSBs.
    function automatic logic [IDX_MAX_W-1:0] bpred_index(
        input logic [XLEN-1:0]      pc,
        input logic [IDX_MAX_W-1:0] ghr,
        input int unsigned          iw,
        input int unsigned          hw
    );
        logic [IDX_MAX_W-1:0] base;
        logic [IDX_MAX_W-1:0] mask;
        logic [IDX_MAX_W-1:0] hist;
        base = IDX_MAX_W'(pc >> 2);
        mask = IDX_MAX_W'((16'(1) << iw) - 16'(1));
        hist = (hw == 0) ? '0 : IDX_MAX_W'(ghr << (iw - hw));
        return (base ^ hist) & mask;
    endfunction

    // pc[31:iw+2], zero-extended to TAG_W.
    function automatic logic [TAG_W-1:0] bpred_tag(
        input logic [XLEN-1:0] pc,
        input int unsigned     iw
    );
        return TAG_W'(pc >> (iw + 2));
    endfunction

endpackage

// File: rtl/bpred_table.sv
// BTB storage: ENTRIES-deep flop array with asynchronous clear.
// Ports: clk, reset (async, active-low); lk_idx/lk_entry fetch-side read;
// up_idx/up_entry resolve-side read; wr_en/wr_idx/wr_entry write port.
module bpred_table
    import bpred_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IW      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [IW-1:0] lk_idx,
    output bpred_entry_t lk_entry,
    input  logic [IW-1:0] up_idx,
    output bpred_entry_t up_entry,
    input  logic         wr_en,
    input  logic [IW-1:0] wr_idx,
    input  bpred_entry_t wr_entry
);

    bpred_entry_t mem [ENTRIES];

    // Reads return pre-write contents; the write lands at the edge.
    assign lk_entry = mem[lk_idx];
    // Second read port serves the resolve-side hit check.
    assign up_entry = mem[up_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit direction counters and
// optional gshare indexing; resolves in EX and raises flush/redirect.
// Ports: clk, reset (async, active-low); if_pc -> pred_taken/pred_target
// (combinational lookup); ex_* resolve inputs -> mispredict/redirect_pc
// (combinational); branch_cnt/mispred_cnt saturating perf counters.
module branch_predictor
    import bpred_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned HIST_W  = 0,
    parameter int unsigned PRED_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_cond,
    input  logic             ex_is_jump,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IW  = $clog2(ENTRIES);
    localparam int unsigned GHW = (HIST_W > 0) ? HIST_W : 1;

    logic [GHW-1:0]       ghr;
    logic [IDX_MAX_W-1:0] ghr_ext;
    logic [IW-1:0]        lk_idx;
    logic [IW-1:0]        up_idx;
    bpred_entry_t         lk_entry;
    bpred_entry_t         up_entry;
    logic                 lk_hit_taken;
    logic                 up_hit;
    logic                 wr_en;
    bpred_entry_t         wr_entry;

    assign ghr_ext = (HIST_W > 0) ? IDX_MAX_W'(ghr) : '0;
    assign lk_idx  = IW'(bpred_index(if_pc, ghr_ext, IW, HIST_W));
    assign up_idx  = IW'(bpred_index(ex_pc, ghr_ext, IW, HIST_W));

    bpred_table #(
        .ENTRIES (ENTRIES),
        .IW      (IW)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .lk_idx   (lk_idx),
        .lk_entry (lk_entry),
        .up_idx   (up_idx),
        .up_entry (up_entry),
        .wr_en    (wr_en),
        .wr_idx   (up_idx),
        .wr_entry (wr_entry)
    );

    // Fetch-side lookup; an alias (tag mismatch) counts as a miss.
    assign lk_hit_taken = lk_entry.valid && (lk_entry.tag == bpred_tag(if_pc, IW))
                          && lk_entry.ctr[1];
    assign pred_taken   = (PRED_EN != 0) && lk_hit_taken;
    assign pred_target  = lk_hit_taken ? lk_entry.target : if_pc + 32'd4;

    // EX-side flush request; held low while in reset.
    assign mispredict  = reset && ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    assign up_hit = up_entry.valid && (up_entry.tag == bpred_tag(ex_pc, IW));

    // Train on hit, allocate on taken miss, leave untouched on not-taken miss.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (ex_valid) begin
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next(up_entry.ctr, ex_taken);
                if (ex_taken) begin
                    wr_entry.target = ex_target;
                end
            end else if (ex_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid:  1'b1,
                             tag:    bpred_tag(ex_pc, IW),
                             target: ex_target,
                             ctr:    ex_is_jump ? CTR_ST : CTR_WT};
            end
        end
    end

    // Non-speculative global history, conditional branches only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if ((HIST_W > 0) && ex_valid && ex_is_cond) begin
            ghr <= GHW'({ghr, ex_taken});
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ex_valid && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: default instance, a PRED_EN=0
// instance with narrow counters sharing its stimulus, and a HIST_W=2 instance.
module tb_branch_predictor;

    localparam int K_PT = 0, K_PTG = 1, K_MP = 2, K_RPC = 3, K_BC = 4, K_MC = 5;
    localparam int K_NPT = 6, K_NPTG = 7, K_NBC = 8, K_NMC = 9, K_NMP = 10, K_NRPC = 11;
    localparam int K_GPT = 12, K_GPTG = 13, K_GMP = 14, K_GRPC = 15, K_GBC = 16, K_GMC = 17;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        if_pc_dummy;
    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic        ex_valid, ex_is_cond, ex_is_jump, ex_taken, ex_pred_taken;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        n_pred_taken, n_mispredict;
    logic [31:0] n_pred_target, n_redirect_pc;
    logic [2:0]  n_branch_cnt, n_mispred_cnt;

    logic [31:0] g_if_pc, g_ex_pc, g_ex_target, g_ex_pred_target;
    logic        g_ex_valid, g_ex_is_cond, g_ex_is_jump, g_ex_taken, g_ex_pred_taken;
    logic        g_pred_taken, g_mispredict;
    logic [31:0] g_pred_target, g_redirect_pc;
    logic [15:0] g_branch_cnt, g_mispred_cnt;

    branch_predictor #(.ENTRIES(16), .HIST_W(0), .PRED_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.ENTRIES(16), .HIST_W(0), .PRED_EN(0), .CNT_W(3)) u_nopred (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(n_pred_taken), .pred_target(n_pred_target),
        .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(n_mispredict), .redirect_pc(n_redirect_pc),
        .branch_cnt(n_branch_cnt), .mispred_cnt(n_mispred_cnt)
    );

    branch_predictor #(.ENTRIES(16), .HIST_W(2), .PRED_EN(1), .CNT_W(16)) u_gshare (
        .clk(clk), .reset(reset), .if_pc(g_if_pc),
        .pred_taken(g_pred_taken), .pred_target(g_pred_target),
        .ex_valid(g_ex_valid), .ex_is_cond(g_ex_is_cond), .ex_is_jump(g_ex_is_jump),
        .ex_pc(g_ex_pc), .ex_taken(g_ex_taken), .ex_target(g_ex_target),
        .ex_pred_taken(g_ex_pred_taken), .ex_pred_target(g_ex_pred_target),
        .mispredict(g_mispredict), .redirect_pc(g_redirect_pc),
        .branch_cnt(g_branch_cnt), .mispred_cnt(g_mispred_cnt)
    );

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_PT:    return 32'(pred_taken);
            K_PTG:   return pred_target;
            K_MP:    return 32'(mispredict);
            K_RPC:   return redirect_pc;
            K_BC:    return 32'(branch_cnt);
            K_MC:    return 32'(mispred_cnt);
            K_NPT:   return 32'(n_pred_taken);
            K_NPTG:  return n_pred_target;
            K_NBC:   return 32'(n_branch_cnt);
            K_NMC:   return 32'(n_mispred_cnt);
            K_NMP:   return 32'(n_mispredict);
            K_NRPC:  return n_redirect_pc;
            K_GPT:   return 32'(g_pred_taken);
            K_GPTG:  return g_pred_target;
            K_GMP:   return 32'(g_mispredict);
            K_GRPC:  return g_redirect_pc;
            K_GBC:   return 32'(g_branch_cnt);
            K_GMC:   return 32'(g_mispred_cnt);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drain every expectation queued since the last falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (q.size() > 0) begin
            e   = q.pop_front();
            got = actual(e.kind);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, got, e.val);
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] v);
        exp_t e;
        e.nm   = nm;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic cond, input logic jump,
                           input logic taken, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_is_cond     = cond;
        ex_is_jump     = jump;
        ex_pc          = pc;
        ex_taken       = taken;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    // Hand-derived gshare walk at 0x00400010, outcomes T,N,T,N,...
    int g_pt [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    int g_mp [8] = '{1, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int mc_before;
        if_pc_dummy = 1'b0;
        reset = 1'b0;
        if_pc = 32'h0040_0000;
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        g_if_pc = 32'h0040_0010; g_ex_valid = 1'b0; g_ex_is_cond = 1'b1; g_ex_is_jump = 1'b0;
        g_ex_pc = 32'h0040_0010; g_ex_taken = 1'b0; g_ex_target = 32'h0040_0040;
        g_ex_pred_taken = 1'b0; g_ex_pred_target = 32'h0040_0014;

        // Reset: outputs quiescent even with a live mismatching EX input
        chk("rst_pt", K_PT, 0);
        chk("rst_ptg", K_PTG, 32'h0040_0004);
        chk("rst_mp", K_MP, 0);
        chk("rst_rpc", K_RPC, 32'h0040_0040);
        chk("rst_bc", K_BC, 0);
        chk("rst_mc", K_MC, 0);
        chk("rst_gpt", K_GPT, 0);
        step(); step();
        if_pc = 32'h0040_0010;
        chk("rst_hold_bc", K_BC, 0);
        chk("rst_hold_pt", K_PT, 0);
        step();
        reset = 1'b1;
        ex_valid = 1'b0;
        step();

        // Cold branch; same-cycle lookup sees pre-update contents
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        chk("cold_mp", K_MP, 1);
        chk("cold_rpc", K_RPC, 32'h0040_0040);
        chk("cold_same_pt", K_PT, 0);
        chk("cold_nmp", K_NMP, 1);
        chk("cold_nrpc", K_NRPC, 32'h0040_0040);
        step();
        ex_valid = 1'b0;
        chk("cold_pt", K_PT, 1);
        chk("cold_ptg", K_PTG, 32'h0040_0040);
        chk("cold_bc", K_BC, 1);
        chk("cold_mc", K_MC, 1);
        chk("nopred_pt", K_NPT, 0);
        chk("nopred_trained_ptg", K_NPTG, 32'h0040_0040);
        step();

        // Saturation then hysteresis
        for (int i = 0; i < 3; i++) begin
            resolve(32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
            chk("sat_mp", K_MP, 0);
            step();
        end
        ex_valid = 1'b0;
        chk("sat_bc", K_BC, 4);
        chk("sat_mc", K_MC, 1);
        step();
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        chk("nt1_mp", K_MP, 1);
        chk("nt1_rpc", K_RPC, 32'h0040_0014);
        step();
        ex_valid = 1'b0;
        chk("hyst_pt", K_PT, 1);
        chk("hyst_ptg", K_PTG, 32'h0040_0040);
        chk("hyst_mc", K_MC, 2);
        step();
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        chk("nt2_mp", K_MP, 1);
        step();
        ex_valid = 1'b0;
        chk("nt2_pt", K_PT, 0);
        chk("nt2_ptg", K_PTG, 32'h0040_0014);
        chk("nt2_bc", K_BC, 6);
        chk("nt2_mc", K_MC, 3);
        step();

        // JR target change
        if_pc = 32'h0040_0100;
        resolve(32'h0040_0100, 1'b0, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0104);
        chk("jr1_mp", K_MP, 1);
        chk("jr1_rpc", K_RPC, 32'h0040_0200);
        step();
        ex_valid = 1'b0;
        chk("jr1_pt", K_PT, 1);
        chk("jr1_ptg", K_PTG, 32'h0040_0200);
        step();
        resolve(32'h0040_0100, 1'b0, 1'b1, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
        chk("jr2_mp", K_MP, 1);
        chk("jr2_rpc", K_RPC, 32'h0040_0300);
        step();
        ex_valid = 1'b0;
        chk("jr2_ptg", K_PTG, 32'h0040_0300);
        chk("jr2_bc", K_BC, 8);
        chk("jr2_mc", K_MC, 5);
        step();

        // Same-cycle update (ctr 01 -> 10) then alias eviction
        if_pc = 32'h0040_0010;
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        chk("same_pt", K_PT, 0);
        chk("same_ptg", K_PTG, 32'h0040_0014);
        chk("same_mp", K_MP, 1);
        step();
        ex_valid = 1'b0;
        chk("same_after_pt", K_PT, 1);
        step();
        resolve(32'h0040_0050, 1'b1, 1'b0, 1'b1, 32'h0040_0080, 1'b0, 32'h0040_0054);
        chk("alias_mp", K_MP, 1);
        chk("alias_rpc", K_RPC, 32'h0040_0080);
        chk("alias_pre_pt", K_PT, 1);
        step();
        ex_valid = 1'b0;
        chk("evicted_pt", K_PT, 0);
        chk("evicted_ptg", K_PTG, 32'h0040_0014);
        chk("alias_mc", K_MC, 7);
        step();
        if_pc = 32'h0040_0050;
        chk("alias_new_pt", K_PT, 1);
        chk("alias_new_ptg", K_PTG, 32'h0040_0080);
        step();

        // Not-taken miss allocates nothing
        if_pc = 32'h0040_0020;
        resolve(32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0060, 1'b0, 32'h0040_0024);
        chk("ntmiss_mp", K_MP, 0);
        chk("ntmiss_rpc", K_RPC, 32'h0040_0024);
        step();
        ex_valid = 1'b0;
        chk("ntmiss_pt", K_PT, 0);
        chk("ntmiss_ptg", K_PTG, 32'h0040_0024);
        step();

        // ex_valid=0 with mismatching carried prediction: inert
        resolve(32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        ex_valid = 1'b0;
        chk("bubble_mp", K_MP, 0);
        step(); step();
        chk("final_bc", K_BC, 11);
        chk("final_mc", K_MC, 7);
        chk("nopred_bc_sat", K_NBC, 7);
        chk("nopred_mc", K_NMC, 7);
        step();

        // gshare alternating pattern
        mc_before = 0;
        for (int i = 0; i < 8; i++) begin
            g_ex_valid       = 1'b1;
            g_ex_taken       = (i % 2 == 0);
            g_ex_pred_taken  = (g_pt[i] != 0);
            g_ex_pred_target = (g_pt[i] != 0) ? 32'h0040_0040 : 32'h0040_0014;
            chk($sformatf("gs_pt_%0d", i), K_GPT, 32'(g_pt[i]));
            chk($sformatf("gs_ptg_%0d", i), K_GPTG,
                (g_pt[i] != 0) ? 32'h0040_0040 : 32'h0040_0014);
            chk($sformatf("gs_mp_%0d", i), K_GMP, 32'(g_mp[i]));
            chk($sformatf("gs_rpc_%0d", i), K_GRPC,
                (i % 2 == 0) ? 32'h0040_0040 : 32'h0040_0014);
            chk($sformatf("gs_mc_%0d", i), K_GMC, 32'(mc_before));
            chk($sformatf("gs_bc_%0d", i), K_GBC, 32'(i));
            step();
            mc_before = mc_before + g_mp[i];
        end
        g_ex_valid = 1'b0;
        chk("gs_final_mc", K_GMC, 2);
        chk("gs_final_bc", K_GBC, 8);
        step();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
